// File: rtl/alu_issue_unit_if.sv
// Bundle between the decode stage, the ALU and the writeback stage.
// The request/response handshakes and the ALU operand/result wires travel
// together so the issue unit takes a single bus port.
interface alu_issue_unit_if #(
  parameter int TAG_W = 5
);
  // Request side (from decode)
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic             req_funct7b5;
  logic             req_is_imm;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [31:0]      req_imm;
  logic [TAG_W-1:0] req_tag;

  // ALU side
  logic [31:0]      read_data1;
  logic [31:0]      read_data2;
  logic [3:0]       control_signal;
  logic [31:0]      result;
  logic             zero_bit;

  // Response side (to writeback)
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  // Environment: issues requests, models the ALU, consumes responses
  modport master (
    output req_valid, req_funct3, req_funct7b5, req_is_imm,
           req_rs1, req_rs2, req_imm, req_tag,
    input  req_ready,
    input  read_data1, read_data2, control_signal,
    output result, zero_bit,
    input  rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
    output rsp_ready
  );

  // Issue unit
  modport slave (
    input  req_valid, req_funct3, req_funct7b5, req_is_imm,
           req_rs1, req_rs2, req_imm, req_tag,
    output req_ready,
    output read_data1, read_data2, control_signal,
    input  result, zero_bit,
    output rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue_unit.sv
// ALU issue unit: queues decoded R/I-type requests, maps funct3/funct7 to
// the 4-bit ALU control code, drives the ALU for ALU_LAT cycles and returns
// the captured result on a valid/ready response port, strictly in order.
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN -- when defined, unsupported
// funct3 values are flagged and answered with rsp_err=1 without touching
// the ALU; when undefined they execute as ADD and rsp_err is tied low.
module alu_issue_unit #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_XOR = 4'b0100;
  localparam logic [3:0] CTRL_SLT = 4'b0101;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef struct packed {
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic             err;
`endif
    logic [3:0]       ctrl;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  entry_t          mem [DEPTH];
  entry_t          head_reg;
  entry_t          push_entry;
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            head_valid_reg;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Sequencer and registered outputs
  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [31:0]      read_data1_reg;
  logic [31:0]      read_data2_reg;
  logic [3:0]       ctrl_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_result_reg;
  logic             rsp_zero_reg;
  logic [TAG_W-1:0] rsp_tag_reg;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = bus.req_valid && !full;
  // head_reg is one cycle behind the pointers, so the head is only consumed
  // once head_valid_reg confirms it; IDLE is never entered sooner than two
  // cycles after a pop, which leaves time for both to catch up.
  assign pop   = (state_reg == IDLE) && head_valid_reg;

  // Decode the request into the ALU control code and the operand pair
  always_comb begin
    push_entry     = '0;
    push_entry.op1 = bus.req_rs1;
    push_entry.op2 = bus.req_is_imm ? bus.req_imm : bus.req_rs2;
    push_entry.tag = bus.req_tag;
    case (bus.req_funct3)
      3'b000:  push_entry.ctrl = (bus.req_funct7b5 && !bus.req_is_imm) ? CTRL_SUB : CTRL_ADD;
      3'b111:  push_entry.ctrl = CTRL_AND;
      3'b110:  push_entry.ctrl = CTRL_OR;
      3'b100:  push_entry.ctrl = CTRL_XOR;
      3'b010:  push_entry.ctrl = CTRL_SLT;
      default: begin
        // Shifts and SLTU are not handled by this ALU
        push_entry.ctrl = CTRL_ADD;
`ifdef ALU_ISSUE_ILLEGAL_EN
        push_entry.err  = 1'b1;
`endif
      end
    endcase
  end

  // Entry write and registered head read; unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end
    head_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  // FIFO pointer bookkeeping and head-valid tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      head_valid_reg <= !empty;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic rsp_err_reg;
`endif

  // Issue sequencer: pop, drive the ALU for ALU_LAT cycles, hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      read_data1_reg <= '0;
      read_data2_reg <= '0;
      ctrl_reg       <= '0;
      tag_reg        <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_tag_reg    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            if (head_reg.err) begin
              // Answer directly; ALU operands keep their previous values
              rsp_valid_reg  <= 1'b1;
              rsp_result_reg <= '0;
              rsp_zero_reg   <= 1'b0;
              rsp_tag_reg    <= head_reg.tag;
              rsp_err_reg    <= 1'b1;
              state_reg      <= RESP;
            end else
`endif
            begin
              read_data1_reg <= head_reg.op1;
              read_data2_reg <= head_reg.op2;
              ctrl_reg       <= head_reg.ctrl;
              tag_reg        <= head_reg.tag;
              cnt_reg        <= CNT_INIT;
              state_reg      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == CNT_ONE) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= bus.result;
            rsp_zero_reg   <= bus.zero_bit;
            rsp_tag_reg    <= tag_reg;
`ifdef ALU_ISSUE_ILLEGAL_EN
            rsp_err_reg    <= 1'b0;
`endif
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = !full;
  assign bus.read_data1     = read_data1_reg;
  assign bus.read_data2     = read_data2_reg;
  assign bus.control_signal = ctrl_reg;
  assign bus.rsp_valid      = rsp_valid_reg;
  assign bus.rsp_result     = rsp_result_reg;
  assign bus.rsp_zero       = rsp_zero_reg;
  assign bus.rsp_tag        = rsp_tag_reg;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign bus.rsp_err        = rsp_err_reg;
`else
  assign bus.rsp_err        = 1'b0;
`endif
endmodule
